// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoded control bundle, operands and register specifiers at
// the end of ID and presents them to EX one cycle later. A load in EX whose
// destination feeds the instruction in ID raises Stall. Stalls and flushes
// insert a bubble into EX. A saturating counter tracks the inserted bubbles.
module id_ex_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Freeze,
  input  logic              Flush,
  // Control bundle for the instruction in ID
  input  logic              ALUSrc,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              Beq,
  input  logic              Jump,
  input  logic              RegWrite,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        MemToReg,
  input  logic [2:0]        ALUOp,
  // Datapath values and register specifiers for the instruction in ID
  input  logic [DATA_W-1:0] PCPlus4,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] SignExtImm,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [5:0]        Funct,
  // Registered copies presented to EX
  output logic              ALUSrc_ex,
  output logic              MemWrite_ex,
  output logic              MemRead_ex,
  output logic              Beq_ex,
  output logic              Jump_ex,
  output logic              RegWrite_ex,
  output logic [1:0]        RegDst_ex,
  output logic [1:0]        MemToReg_ex,
  output logic [2:0]        ALUOp_ex,
  output logic [DATA_W-1:0] PCPlus4_ex,
  output logic [DATA_W-1:0] ReadData1_ex,
  output logic [DATA_W-1:0] ReadData2_ex,
  output logic [DATA_W-1:0] SignExtImm_ex,
  output logic [4:0]        Rs_ex,
  output logic [4:0]        Rt_ex,
  output logic [4:0]        Rd_ex,
  output logic [5:0]        Funct_ex,
  output logic              Valid_ex,
  output logic              Stall,
  output logic [CNT_W-1:0]  BubbleCount
);

  typedef struct packed {
    logic              alu_src;
    logic              mem_write;
    logic              mem_read;
    logic              beq;
    logic              jump;
    logic              reg_write;
    logic [1:0]        reg_dst;
    logic [1:0]        mem_to_reg;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
  } ex_t;

  ex_t              ex_in;
  ex_t              ex_q, ex_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             uses_rs;
  logic             uses_rt;
  logic             rs_match;
  logic             rt_match;
  logic             hz;
  logic             bubble;

  // Bundle the ID-stage inputs into the EX payload layout
  always_comb begin
    ex_in            = '0;
    ex_in.alu_src    = ALUSrc;
    ex_in.mem_write  = MemWrite;
    ex_in.mem_read   = MemRead;
    ex_in.beq        = Beq;
    ex_in.jump       = Jump;
    ex_in.reg_write  = RegWrite;
    ex_in.reg_dst    = RegDst;
    ex_in.mem_to_reg = MemToReg;
    ex_in.alu_op     = ALUOp;
    ex_in.pc_plus4   = PCPlus4;
    ex_in.rd1        = ReadData1;
    ex_in.rd2        = ReadData2;
    ex_in.imm        = SignExtImm;
    ex_in.rs         = Rs;
    ex_in.rt         = Rt;
    ex_in.rd         = Rd;
    ex_in.funct      = Funct;
  end

  // Load-use detection: a valid load in EX writing a register the ID
  // instruction actually reads. Jumps read no Rs; Rt is read by R-type,
  // stores (data) and branches (compare).
  always_comb begin
    uses_rs  = ~Jump;
    uses_rt  = ~ALUSrc | MemWrite | Beq;
    rs_match = uses_rs & (ex_q.rt == Rs);
    rt_match = uses_rt & (ex_q.rt == Rt);
    hz       = ex_q.mem_read & valid_q & (ex_q.rt != 5'd0) & (rs_match | rt_match);
    // A flush kills the ID instruction anyway, so there is nothing to hold.
    Stall    = hz & ~Flush;
    bubble   = Flush | hz;
  end

  // Next-state: hold on Freeze, else load, turning the slot into a bubble
  // on flush or hazard.
  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!Freeze) begin
      ex_d = ex_in;
      if (bubble) begin
        // Only side-effecting controls are cleared; the rest are don't-care.
        ex_d.mem_write = 1'b0;
        ex_d.mem_read  = 1'b0;
        ex_d.beq       = 1'b0;
        ex_d.jump      = 1'b0;
        ex_d.reg_write = 1'b0;
        valid_d        = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        valid_d = 1'b1;
      end
    end
  end

  // Pipeline state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drive EX-facing outputs straight from the registers
  always_comb begin
    ALUSrc_ex     = ex_q.alu_src;
    MemWrite_ex   = ex_q.mem_write;
    MemRead_ex    = ex_q.mem_read;
    Beq_ex        = ex_q.beq;
    Jump_ex       = ex_q.jump;
    RegWrite_ex   = ex_q.reg_write;
    RegDst_ex     = ex_q.reg_dst;
    MemToReg_ex   = ex_q.mem_to_reg;
    ALUOp_ex      = ex_q.alu_op;
    PCPlus4_ex    = ex_q.pc_plus4;
    ReadData1_ex  = ex_q.rd1;
    ReadData2_ex  = ex_q.rd2;
    SignExtImm_ex = ex_q.imm;
    Rs_ex         = ex_q.rs;
    Rt_ex         = ex_q.rt;
    Rd_ex         = ex_q.rd;
    Funct_ex      = ex_q.funct;
    Valid_ex      = valid_q;
    BubbleCount   = cnt_q;
  end

endmodule
